rpn_sequencer: RTL and testbench

Command sequencer that drives the 4-bit, 8-deep LIFO stack and turns it into a reverse-Polish evaluator. It accepts one command at a time over a valid/ready handshake and issues the matching Push/Pop pulses to the stack. It captures popped operands from the stack's registered data output, computes 4-bit results and pushes them back. It sits directly upstream of the stack, which it feeds, and also consumes the stack's data and flag outputs.

---
 rtl/rpn_sequencer_if.sv | 30 +++
 rtl/rpn_sequencer.sv | 177 +++++++++++++++++
 tb/tb_rpn_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_sequencer_if.sv
// rpn_sequencer_if
// Command-side bundle of the RPN sequencer.
//   Cmd_Valid/Cmd_Ready  : command handshake (accept on Valid & Ready at a rising edge)
//   Cmd_Op[2:0]          : 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 XOR, 7 DUP
//   Cmd_Imm[3:0]         : immediate for PUSH
//   Result[3:0]          : last computed, pushed or popped value
//   Result_Valid         : one-cycle pulse when Result updates
//   Error                : one-cycle pulse on a rejected command or flag inconsistency
//   Depth[3:0]           : shadow stack occupancy 0..8
// master = command issuer, slave = sequencer.
interface rpn_sequencer_if;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [2:0] Cmd_Op;
  logic [3:0] Cmd_Imm;
  logic [3:0] Result;
  logic       Result_Valid;
  logic       Error;
  logic [3:0] Depth;

  modport master (
    output Cmd_Valid, Cmd_Op, Cmd_Imm,
    input  Cmd_Ready, Result, Result_Valid, Error, Depth
  );

  modport slave (
    input  Cmd_Valid, Cmd_Op, Cmd_Imm,
    output Cmd_Ready, Result, Result_Valid, Error, Depth
  );
endinterface

// File: rtl/rpn_sequencer.sv
// rpn_sequencer
// Drives a 4-bit x 8-deep LIFO stack as a reverse-Polish evaluator.
// Ports:
//   Clk, Rst      : clock (rising edge), synchronous active-high reset
//   cmd           : rpn_sequencer_if.slave command/result bundle
//   Stk_Data_In   : data to stack (valid while Stk_Push)
//   Stk_Push      : push strobe to stack
//   Stk_Pop       : pop strobe to stack
//   Stk_Data_Out  : stack popped data, valid the cycle after Stk_Pop
//   Stk_Full      : stack full flag
//   Stk_Empty     : stack empty flag
module rpn_sequencer (
  input  logic             Clk,
  input  logic             Rst,
  rpn_sequencer_if.slave   cmd,
  output logic [3:0]       Stk_Data_In,
  output logic             Stk_Push,
  output logic             Stk_Pop,
  input  logic [3:0]       Stk_Data_Out,
  input  logic             Stk_Full,
  input  logic             Stk_Empty
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP1, S_POP2, S_CALC, S_PUSH1, S_PUSH2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_DUP
  } op_t;

  state_t     state_q;
  op_t        op_q;
  op_t        cmd_op;
  logic [3:0] a_q;
  logic [3:0] depth_q;
  logic [3:0] result_q;
  logic       result_valid_q;
  logic       error_q;
  logic [3:0] stk_data_in_q;
  logic       stk_push_q;
  logic       stk_pop_q;

  logic       legal_d;
  logic       binary_q;
  logic       flags_bad_d;
  logic [3:0] alu_d;

  assign cmd_op = op_t'(cmd.Cmd_Op);

  // Legality of the offered command against the shadow depth.
  always_comb begin
    legal_d = 1'b1;
    unique case (cmd_op)
      OP_PUSH:                        legal_d = (depth_q <= 4'd7);
      OP_POP:                         legal_d = (depth_q >= 4'd1);
      OP_ADD, OP_SUB, OP_AND, OP_XOR: legal_d = (depth_q >= 4'd2);
      OP_DUP:                         legal_d = (depth_q >= 4'd1) && (depth_q <= 4'd7);
      default:                        legal_d = 1'b1;
    endcase
  end

  assign binary_q    = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                       (op_q == OP_AND) || (op_q == OP_XOR);
  assign flags_bad_d = ((depth_q == 4'd0) != Stk_Empty) ||
                       ((depth_q == 4'd8) != Stk_Full);

  // In CALC the stack output holds B (next) for binary ops, or the
  // single popped value for POP/DUP, which passes through unchanged.
  always_comb begin
    alu_d = Stk_Data_Out;
    unique case (op_q)
      OP_ADD:  alu_d = Stk_Data_Out + a_q;
      OP_SUB:  alu_d = Stk_Data_Out - a_q;
      OP_AND:  alu_d = Stk_Data_Out & a_q;
      OP_XOR:  alu_d = Stk_Data_Out ^ a_q;
      default: alu_d = Stk_Data_Out;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= S_IDLE;
      op_q           <= OP_NOP;
      a_q            <= '0;
      depth_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      stk_data_in_q  <= '0;
      stk_push_q     <= 1'b0;
      stk_pop_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      stk_push_q     <= 1'b0;
      stk_pop_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flags_bad_d) error_q <= 1'b1;
          if (cmd.Cmd_Valid) begin
            op_q <= cmd_op;
            if (!legal_d) begin
              error_q <= 1'b1;
            end else begin
              unique case (cmd_op)
                OP_PUSH: begin
                  state_q       <= S_PUSH1;
                  stk_push_q    <= 1'b1;
                  stk_data_in_q <= cmd.Cmd_Imm;
                end
                OP_NOP: ;
                default: begin
                  state_q   <= S_POP1;
                  stk_pop_q <= 1'b1;
                end
              endcase
            end
          end
        end
        S_POP1: begin
          depth_q <= depth_q - 4'd1;
          if (binary_q) begin
            state_q   <= S_POP2;
            stk_pop_q <= 1'b1;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_POP2: begin
          depth_q <= depth_q - 4'd1;
          a_q     <= Stk_Data_Out;
          state_q <= S_CALC;
        end
        S_CALC: begin
          if (op_q == OP_POP) begin
            result_q       <= Stk_Data_Out;
            result_valid_q <= 1'b1;
            state_q        <= S_IDLE;
          end else begin
            stk_data_in_q <= alu_d;
            stk_push_q    <= 1'b1;
            state_q       <= S_PUSH1;
          end
        end
        S_PUSH1: begin
          depth_q <= depth_q + 4'd1;
          if (op_q == OP_DUP) begin
            stk_push_q <= 1'b1;
            state_q    <= S_PUSH2;
          end else begin
            result_q       <= stk_data_in_q;
            result_valid_q <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        S_PUSH2: begin
          depth_q        <= depth_q + 4'd1;
          result_q       <= stk_data_in_q;
          result_valid_q <= 1'b1;
          state_q        <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd.Cmd_Ready    = (state_q == S_IDLE);
  assign cmd.Result       = result_q;
  assign cmd.Result_Valid = result_valid_q;
  assign cmd.Error        = error_q;
  assign cmd.Depth        = depth_q;
  assign Stk_Data_In      = stk_data_in_q;
  assign Stk_Push         = stk_push_q;
  assign Stk_Pop          = stk_pop_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer
// Directed bench for rpn_sequencer with a behavioural 4-bit x 8 LIFO stack.
module tb_rpn_sequencer;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, AND = 3'd5, XOR = 3'd6, DUP = 3'd7;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] Stk_Data_In;
  logic       Stk_Push;
  logic       Stk_Pop;
  logic [3:0] Stk_Data_Out;
  logic       Stk_Full;
  logic       Stk_Empty;

  int n_checks = 0;
  int n_fail   = 0;

  rpn_sequencer_if cmd_if ();

  rpn_sequencer dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .cmd          (cmd_if),
    .Stk_Data_In  (Stk_Data_In),
    .Stk_Push     (Stk_Push),
    .Stk_Pop      (Stk_Pop),
    .Stk_Data_Out (Stk_Data_Out),
    .Stk_Full     (Stk_Full),
    .Stk_Empty    (Stk_Empty)
  );

  always #5 Clk = ~Clk;

  // Stack model: registered popped data, flags from registered count.
  // flip_empty corrupts the empty flag to exercise the consistency check.
  logic [3:0] mem [8];
  logic [3:0] cnt;
  logic [3:0] cnt_m1;
  logic       flip_empty = 1'b0;
  assign cnt_m1    = cnt - 4'd1;
  assign Stk_Empty = (cnt == 4'd0) ^ flip_empty;
  assign Stk_Full  = (cnt == 4'd8);

  always @(posedge Clk) begin
    if (Rst) begin
      cnt          <= '0;
      Stk_Data_Out <= '0;
    end else if (Stk_Push && cnt < 4'd8) begin
      mem[cnt[2:0]] <= Stk_Data_In;
      cnt           <= cnt + 4'd1;
    end else if (Stk_Pop && cnt != 4'd0) begin
      Stk_Data_Out <= mem[cnt_m1[2:0]];
      cnt          <= cnt_m1;
    end
  end

  // Log of every value strobed into the stack.
  logic [3:0] push_log [$];
  always @(posedge Clk) if (!Rst && Stk_Push) push_log.push_back(Stk_Data_In);

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Offer one command for one accept edge; returns at cycle 1.
  task automatic send(input logic [2:0] op, input logic [3:0] imm);
    cmd_if.Cmd_Valid = 1'b1;
    cmd_if.Cmd_Op    = op;
    cmd_if.Cmd_Imm   = imm;
    cyc();
    cmd_if.Cmd_Valid = 1'b0;
  endtask

  // Legal command, returns in the cycle where Result_Valid pulses.
  task automatic exec(input logic [2:0] op, input logic [3:0] imm);
    int n;
    n = (op == PUSH) ? 2 : (op == POP) ? 3 : (op == NOP) ? 1 : 5;
    send(op, imm);
    for (int i = 1; i < n; i++) cyc();
  endtask

  task automatic reset_dut();
    Rst = 1'b1;
    cyc();
    cyc();
    Rst = 1'b0;
    push_log.delete();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    cyc();
    cyc();
    n_checks++; if (cmd_if.Cmd_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_if.Cmd_Ready); end
    n_checks++; if (cmd_if.Result !== 4'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", cmd_if.Result); end
    n_checks++; if (cmd_if.Result_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b expected 0", cmd_if.Result_Valid); end
    n_checks++; if (cmd_if.Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", cmd_if.Error); end
    n_checks++; if (cmd_if.Depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth: got %0d expected 0", cmd_if.Depth); end
    n_checks++; if ({Stk_Push, Stk_Pop} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b expected 00", {Stk_Push, Stk_Pop}); end
    n_checks++; if (Stk_Data_In !== 4'h0) begin n_fail++; $display("FAIL reset_data_in: got %h expected 0", Stk_Data_In); end
    Rst = 1'b0;
  endtask

  task automatic test_add();
    reset_dut();
    send(PUSH, 4'h3);
    n_checks++; if ({Stk_Push, Stk_Data_In} !== {1'b1, 4'h3}) begin n_fail++; $display("FAIL push1_strobe: got %b/%h expected 1/3", Stk_Push, Stk_Data_In); end
    cyc();
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result} !== {1'b1, 4'h3}) begin n_fail++; $display("FAIL push1_result: got %b/%h expected 1/3", cmd_if.Result_Valid, cmd_if.Result); end
    exec(PUSH, 4'h5);
    send(ADD, 4'h0);
    n_checks++; if ({Stk_Pop, Stk_Push, cmd_if.Cmd_Ready} !== 3'b100) begin n_fail++; $display("FAIL add_pop1: got %b expected 100", {Stk_Pop, Stk_Push, cmd_if.Cmd_Ready}); end
    cyc();
    n_checks++; if ({Stk_Pop, cmd_if.Depth} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL add_pop2: got %b/%0d expected 1/1", Stk_Pop, cmd_if.Depth); end
    cyc();
    cyc();
    n_checks++; if ({Stk_Push, Stk_Pop, Stk_Data_In} !== {2'b10, 4'h8}) begin n_fail++; $display("FAIL add_push: got %b%b/%h expected 10/8", Stk_Push, Stk_Pop, Stk_Data_In); end
    cyc();
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result} !== {1'b1, 4'h8}) begin n_fail++; $display("FAIL add_result: got %b/%h expected 1/8", cmd_if.Result_Valid, cmd_if.Result); end
    n_checks++; if ({cmd_if.Depth, Stk_Empty} !== {4'd1, 1'b0}) begin n_fail++; $display("FAIL add_depth: got %0d/%b expected 1/0", cmd_if.Depth, Stk_Empty); end
    n_checks++; if (push_log.size() != 3 || push_log[0] !== 4'h3 || push_log[1] !== 4'h5 || push_log[2] !== 4'h8) begin n_fail++; $display("FAIL add_push_log: got %p expected 3,5,8", push_log); end
  endtask

  task automatic test_sub_wrap();
    reset_dut();
    exec(PUSH, 4'h2);
    exec(PUSH, 4'h7);
    exec(SUB, 4'h0);
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'hB, 4'd1}) begin n_fail++; $display("FAIL sub_result: got %b/%h/%0d expected 1/b/1", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
    exec(PUSH, 4'hF);
    exec(PUSH, 4'h1);
    exec(ADD, 4'h0);
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'h0, 4'd2}) begin n_fail++; $display("FAIL add_wrap: got %b/%h/%0d expected 1/0/2", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
    exec(AND, 4'h0);
    n_checks++; if (cmd_if.Result !== 4'h0) begin n_fail++; $display("FAIL and_result: got %h expected 0", cmd_if.Result); end
    exec(PUSH, 4'hC);
    exec(PUSH, 4'h6);
    exec(AND, 4'h0);
    n_checks++; if ({cmd_if.Result, cmd_if.Depth} !== {4'h4, 4'd2}) begin n_fail++; $display("FAIL and_result2: got %h/%0d expected 4/2", cmd_if.Result, cmd_if.Depth); end
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 8; i++) exec(PUSH, 4'(i));
    n_checks++; if ({cmd_if.Depth, Stk_Full} !== {4'd8, 1'b1}) begin n_fail++; $display("FAIL full_depth: got %0d/%b expected 8/1", cmd_if.Depth, Stk_Full); end
    push_log.delete();
    send(PUSH, 4'h9);
    n_checks++; if ({cmd_if.Error, Stk_Push, cmd_if.Cmd_Ready} !== 3'b101) begin n_fail++; $display("FAIL full_reject: got %b expected 101", {cmd_if.Error, Stk_Push, cmd_if.Cmd_Ready}); end
    send(POP, 4'h0);
    n_checks++; if ({cmd_if.Error, Stk_Pop} !== 2'b01) begin n_fail++; $display("FAIL full_err_pulse: got %b expected 01", {cmd_if.Error, Stk_Pop}); end
    cyc();
    cyc();
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'h7, 4'd7}) begin n_fail++; $display("FAIL full_pop: got %b/%h/%0d expected 1/7/7", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
    n_checks++; if (push_log.size() != 0) begin n_fail++; $display("FAIL full_no_push: got %0d pushes expected 0", push_log.size()); end
  endtask

  task automatic test_empty();
    reset_dut();
    send(POP, 4'h0);
    n_checks++; if ({cmd_if.Error, Stk_Pop, cmd_if.Depth} !== {2'b10, 4'd0}) begin n_fail++; $display("FAIL empty_pop: got %b%b/%0d expected 10/0", cmd_if.Error, Stk_Pop, cmd_if.Depth); end
    exec(PUSH, 4'h4);
    send(ADD, 4'h0);
    n_checks++; if ({cmd_if.Error, Stk_Pop, cmd_if.Depth} !== {2'b10, 4'd1}) begin n_fail++; $display("FAIL underflow_add: got %b%b/%0d expected 10/1", cmd_if.Error, Stk_Pop, cmd_if.Depth); end
    send(NOP, 4'h0);
    n_checks++; if ({cmd_if.Error, cmd_if.Result_Valid, cmd_if.Cmd_Ready, cmd_if.Depth} !== {3'b001, 4'd1}) begin n_fail++; $display("FAIL nop: got %b%b%b/%0d expected 001/1", cmd_if.Error, cmd_if.Result_Valid, cmd_if.Cmd_Ready, cmd_if.Depth); end
  endtask

  task automatic test_dup_xor();
    reset_dut();
    exec(PUSH, 4'hA);
    push_log.delete();
    exec(DUP, 4'h0);
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'hA, 4'd2}) begin n_fail++; $display("FAIL dup_result: got %b/%h/%0d expected 1/a/2", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
    n_checks++; if (push_log.size() != 2 || push_log[0] !== 4'hA || push_log[1] !== 4'hA) begin n_fail++; $display("FAIL dup_pushes: got %p expected a,a", push_log); end
    exec(XOR, 4'h0);
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'h0, 4'd1}) begin n_fail++; $display("FAIL xor_result: got %b/%h/%0d expected 1/0/1", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    exec(PUSH, 4'h1);
    exec(PUSH, 4'h2);
    send(ADD, 4'h0);
    cyc();
    cyc();
    push_log.delete();
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    n_checks++; if ({cmd_if.Cmd_Ready, cmd_if.Result_Valid, cmd_if.Error, Stk_Push, Stk_Pop} !== 5'b10000) begin n_fail++; $display("FAIL midreset_ctl: got %b expected 10000", {cmd_if.Cmd_Ready, cmd_if.Result_Valid, cmd_if.Error, Stk_Push, Stk_Pop}); end
    n_checks++; if ({cmd_if.Result, cmd_if.Depth, Stk_Data_In} !== 12'h000) begin n_fail++; $display("FAIL midreset_data: got %h expected 000", {cmd_if.Result, cmd_if.Depth, Stk_Data_In}); end
    cyc();
    n_checks++; if (push_log.size() != 0) begin n_fail++; $display("FAIL midreset_no_push: got %0d pushes expected 0", push_log.size()); end
    exec(PUSH, 4'h6);
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth} !== {1'b1, 4'h6, 4'd1}) begin n_fail++; $display("FAIL midreset_push: got %b/%h/%0d expected 1/6/1", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Depth); end
  endtask

  // Valid held through a busy cycle with a changed immediate: only the
  // value present while Ready is high is taken, and the next command is
  // taken in the completion cycle.
  task automatic test_back_to_back();
    reset_dut();
    cmd_if.Cmd_Valid = 1'b1;
    cmd_if.Cmd_Op    = PUSH;
    cmd_if.Cmd_Imm   = 4'h3;
    cyc();
    cmd_if.Cmd_Imm = 4'h5;
    n_checks++; if ({cmd_if.Cmd_Ready, Stk_Data_In} !== {1'b0, 4'h3}) begin n_fail++; $display("FAIL b2b_busy: got %b/%h expected 0/3", cmd_if.Cmd_Ready, Stk_Data_In); end
    cyc();
    n_checks++; if ({cmd_if.Result_Valid, cmd_if.Result, cmd_if.Cmd_Ready} !== {1'b1, 4'h3, 1'b1}) begin n_fail++; $display("FAIL b2b_first: got %b/%h/%b expected 1/3/1", cmd_if.Result_Valid, cmd_if.Result, cmd_if.Cmd_Ready); end
    cyc();
    cmd_if.Cmd_Valid = 1'b0;
    n_checks++; if ({Stk_Push, Stk_Data_In} !== {1'b1, 4'h5}) begin n_fail++; $display("FAIL b2b_second_push: got %b/%h expected 1/5", Stk_Push, Stk_Data_In); end
    cyc();
    n_checks++; if ({cmd_if.Result, cmd_if.Depth} !== {4'h5, 4'd2}) begin n_fail++; $display("FAIL b2b_second: got %h/%0d expected 5/2", cmd_if.Result, cmd_if.Depth); end
  endtask

  task automatic test_consistency();
    reset_dut();
    flip_empty = 1'b1;
    cyc();
    n_checks++; if (cmd_if.Error !== 1'b1) begin n_fail++; $display("FAIL flag_mismatch: got %b expected 1", cmd_if.Error); end
    cyc();
    n_checks++; if (cmd_if.Error !== 1'b1) begin n_fail++; $display("FAIL flag_persist: got %b expected 1", cmd_if.Error); end
    flip_empty = 1'b0;
    cyc();
    n_checks++; if (cmd_if.Error !== 1'b0) begin n_fail++; $display("FAIL flag_clear: got %b expected 0", cmd_if.Error); end
  endtask

  initial begin
    cmd_if.Cmd_Valid = 1'b0;
    cmd_if.Cmd_Op    = NOP;
    cmd_if.Cmd_Imm   = 4'h0;
    #1;
    test_reset();
    test_add();
    test_sub_wrap();
    test_full();
    test_empty();
    test_dup_xor();
    test_reset_mid();
    test_back_to_back();
    test_consistency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
